// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 initiator driven by a valid/ready command channel
// Ports: clk/rst_n; cmd_* request channel (valid/ready, write, addr, wdata);
// rsp_* response channel (valid/ready, rdata, err, timeout); APB3 master signals
// psel/penable/pwrite/paddr/pwdata out, pready/pslverr/prdata in.
// TIMEOUT_CYCLES bounds ACCESS wait states (0 disables the abort).
module apb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic        pslverr_i,
  input  logic [31:0] prdata_i
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic timeout;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == LIM);
  // Control outputs decode straight from the state register so reset drops them asynchronously.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = cmd_valid_i ? SETUP : IDLE;
      SETUP:  state_nx = ACCESS;
      ACCESS: state_nx = (pready_i || timeout) ? RESP : ACCESS;
      RESP:   state_nx = rsp_ready_i ? IDLE : RESP;
    endcase
    cmd_ready_o = state == IDLE;
    psel_o      = state == SETUP || state == ACCESS;
    penable_o   = state == ACCESS;
    rsp_valid_o = state == RESP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid_i) begin
        pwrite_o <= cmd_write_i;
        paddr_o  <= cmd_addr_i;
        pwdata_o <= cmd_wdata_i;
      end
      // Saturating so the counter cannot wrap when the timeout is disabled.
      if (state == SETUP)
        cnt <= '0;
      else if (state == ACCESS && !pready_i && cnt != '1)
        cnt <= cnt + CW'(1);
      // pready_i takes priority over a simultaneous timeout.
      if (state == ACCESS && pready_i) begin
        rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
        rsp_err_o     <= pslverr_i;
        rsp_timeout_o <= 1'b0;
      end else if (state == ACCESS && timeout) begin
        rsp_rdata_o   <= '0;
        rsp_err_o     <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed scoreboard bench for apb_cmd_master with TIMEOUT_CYCLES = 8
module tb_apb_cmd_master;
  logic clk, rst_n;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  typedef struct packed {logic [31:0] rdata; logic err; logic to;} rsp_t;
  rsp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  apb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_cmd(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic se, input int bp, input logic early);
    rsp_t e;
    int i;
    logic to;
    to = waits >= 8;
    q.push_back('{rdata: (to || w) ? 32'h0 : rd, err: to | se, to: to});
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~w;
    rsp_ready = early;
    chk({tag, ".setup_psel"}, psel, 1);
    chk({tag, ".setup_penable"}, penable, 0);
    chk({tag, ".setup_paddr"}, paddr, a);
    chk({tag, ".setup_pwrite"}, pwrite, w);
    chk({tag, ".setup_pwdata"}, pwdata, wd);
    chk({tag, ".setup_cmd_ready"}, cmd_ready, 0);
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      chk({tag, ".access_penable"}, penable, 1);
      chk({tag, ".access_paddr"}, paddr, a);
      pready = (i == waits);
      prdata = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? se : 1'b1;
    end
    pready = 1'b0; pslverr = 1'b0;
    if (i == 30) chk({tag, ".rsp_wait_bound"}, 0, 1);
    chk({tag, ".access_cycles"}, 32'(i), to ? 32'd8 : 32'(waits + 1));
    if (q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 1, 0);
      e = '0;
    end else begin
      e = q.pop_front();
    end
    chk({tag, ".rdata"}, rsp_rdata, e.rdata);
    chk({tag, ".err"}, rsp_err, e.err);
    chk({tag, ".timeout"}, rsp_timeout, e.to);
    chk({tag, ".resp_psel"}, psel, 0);
    if (bp > 0) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_addr = 32'hDEAD_BEEF;
      repeat (bp) begin
        @(negedge clk);
        chk({tag, ".bp_valid"}, rsp_valid, 1);
        chk({tag, ".bp_rdata"}, rsp_rdata, e.rdata);
        chk({tag, ".bp_err"}, rsp_err, e.err);
        chk({tag, ".bp_cmd_ready"}, cmd_ready, 0);
        chk({tag, ".bp_psel"}, psel, 0);
      end
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".post_valid"}, rsp_valid, 0);
    chk({tag, ".post_cmd_ready"}, cmd_ready, 1);
    chk({tag, ".post_rdata_kept"}, rsp_rdata, e.rdata);
    rsp_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.cmd_ready", cmd_ready, 1);
    chk("rst.psel", psel, 0);
    chk("rst.penable", penable, 0);
    chk("rst.pwrite", pwrite, 0);
    chk("rst.paddr", paddr, 0);
    chk("rst.pwdata", pwdata, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.rsp_err", rsp_err, 0);
    chk("rst.rsp_timeout", rsp_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd("wr0", 1'b1, 32'h0000_0004, 32'h0001_0000, 0, 32'h0, 1'b0, 0, 1'b0);
    do_cmd("rdw", 1'b0, 32'h0000_0004, 32'h0, 3, 32'h0000_1458, 1'b0, 0, 1'b1);
    do_cmd("slverr", 1'b0, 32'h0000_0008, 32'h0, 0, 32'h0000_ABCD, 1'b1, 0, 1'b0);
    do_cmd("tmo", 1'b0, 32'h0000_000C, 32'h0, 100, 32'h0, 1'b0, 0, 1'b0);
    do_cmd("after_tmo", 1'b1, 32'h0000_0010, 32'h0000_0055, 1, 32'h0, 1'b0, 5, 1'b0);
    do_cmd("b2b", 1'b0, 32'h0000_0014, 32'h0, 0, 32'h0000_0077, 1'b0, 0, 1'b0);
    do_cmd("ready_at_limit", 1'b0, 32'h0000_0018, 32'h0, 7, 32'h1234_5678, 1'b0, 0, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_001C; cmd_wdata = 32'h0000_00AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.penable_before", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.psel", psel, 0);
    chk("rst_mid.penable", penable, 0);
    chk("rst_mid.rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.cmd_ready", cmd_ready, 1);
    chk("rst_mid.rsp_valid_after", rsp_valid, 0);
    do_cmd("after_rst", 1'b0, 32'h0000_0020, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
